// File: rtl/psum_pkg.sv
// Shared constants and arithmetic helpers for the psum scratchpad.
package psum_pkg;

  localparam logic MODE_FIFO = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

  // Signed add clamped to the two's complement range of a width-bit word.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned        width);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (s > hi) begin
      return hi;
    end else if (s < lo) begin
      return lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/psum_spad_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, two async read ports.
module psum_spad_mem
  import psum_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/psum_spad_acc.sv
// Partial-sum scratchpad: streaming FIFO mode or addressed read-modify-write
// accumulate mode with a forwarded 2-stage pipeline.
module psum_spad_acc
  import psum_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter bit SATURATE = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mode,
  input  logic              i_wr,
  input  logic              i_rd,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data_in,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_out_valid,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_err
);

  localparam logic [ADDR_W:0]   LP_DEPTH   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LP_CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LP_PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] r_head;
  logic [ADDR_W-1:0] r_tail;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_data_out;
  logic              r_out_valid;
  logic              r_err;
  logic              r_mode;
  logic              r_s1_valid;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [DATA_W-1:0] r_s1_data;
  logic [DATA_W-1:0] r_s1_old;

  logic              w_drain;
  logic              w_fifo;
  logic              w_acc;
  logic              w_full;
  logic              w_empty;
  logic              w_pop_ok;
  logic              w_push_ok;
  logic              w_fifo_err;
  logic [DATA_W-1:0] w_sum;
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_acc_old;
  logic [DATA_W-1:0] w_rdata_a;
  logic [DATA_W-1:0] w_rdata_b;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;

  // Leaving ACC mode spends one cycle retiring the stage-2 write and clearing
  // FIFO pointers; strobes in that cycle are ignored so the write port is free.
  assign w_drain = (r_mode == MODE_ACC) && (i_mode == MODE_FIFO);
  assign w_fifo  = (i_mode == MODE_FIFO) && !w_drain;
  assign w_acc   = (i_mode == MODE_ACC);

  assign w_full     = (r_count == LP_DEPTH);
  assign w_empty    = (r_count == '0);
  assign w_pop_ok   = w_fifo && i_rd && !w_empty;
  assign w_push_ok  = w_fifo && i_wr && (!w_full || w_pop_ok);
  assign w_fifo_err = w_fifo && ((i_wr && !w_push_ok) || (i_rd && !w_pop_ok));

  if (SATURATE) begin : g_sat
    assign w_sum = DATA_W'(sat_add(64'($signed(r_s1_old)), 64'($signed(r_s1_data)),
                                   DATA_W));
  end else begin : g_wrap
    assign w_sum = r_s1_old + r_s1_data;
  end

  // A stage-2 write to the address being read this cycle is not yet in memory.
  assign w_fwd_hit = r_s1_valid && (r_s1_addr == i_addr);
  assign w_acc_old = w_fwd_hit ? w_sum : w_rdata_b;

  // Stage-2 writes and FIFO pushes never coincide: s1 is only valid in ACC mode
  // or during the drain cycle, where pushes are blocked.
  assign w_mem_we    = !i_rst && (r_s1_valid || w_push_ok);
  assign w_mem_waddr = r_s1_valid ? r_s1_addr : r_tail;
  assign w_mem_wdata = r_s1_valid ? w_sum : i_data_in;

  psum_spad_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .i_clk    (i_clk),
    .i_we     (w_mem_we),
    .i_waddr  (w_mem_waddr),
    .i_wdata  (w_mem_wdata),
    .i_raddr_a(r_head),
    .o_rdata_a(w_rdata_a),
    .i_raddr_b(i_addr),
    .o_rdata_b(w_rdata_b)
  );

  // Pointers, occupancy, read data, status pulses and the ACC stage-1 register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_mode      <= MODE_FIFO;
      r_s1_valid  <= 1'b0;
      r_s1_addr   <= '0;
      r_s1_data   <= '0;
      r_s1_old    <= '0;
    end else begin
      r_mode      <= i_mode;
      r_err       <= w_fifo_err;
      r_out_valid <= w_pop_ok || (w_acc && i_rd);
      if (w_pop_ok) begin
        r_data_out <= w_rdata_a;
      end else if (w_acc && i_rd) begin
        r_data_out <= w_acc_old;
      end

      if (w_drain) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push_ok) r_tail <= r_tail + LP_PTR_ONE;
        if (w_pop_ok)  r_head <= r_head + LP_PTR_ONE;
        case ({w_push_ok, w_pop_ok})
          2'b10:   r_count <= r_count + LP_CNT_ONE;
          2'b01:   r_count <= r_count - LP_CNT_ONE;
          default: r_count <= r_count;
        endcase
      end

      r_s1_valid <= w_acc && i_wr;
      if (w_acc && i_wr) begin
        r_s1_addr <= i_addr;
        r_s1_data <= i_data_in;
        r_s1_old  <= w_acc_old;
      end
    end
  end

  assign o_data_out  = r_data_out;
  assign o_out_valid = r_out_valid;
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_count     = r_count;
  assign o_err       = r_err;

endmodule

// File: tb/tb_psum_spad_acc.sv
// Self-checking bench: saturating and wrapping instances driven in lockstep,
// compared against a transaction-level model of the scratchpad.
module tb_psum_spad_acc;

  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic          wr;
  logic          rd;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;

  logic [DW-1:0] s_dout, w_dout;
  logic          s_ov, w_ov, s_full, w_full, s_empty, w_empty, s_err, w_err;
  logic [AW:0]   s_cnt, w_cnt;

  always #5 clk = ~clk;

  psum_spad_acc #(.DATA_W(DW), .DEPTH(DEPTH), .SATURATE(1'b1)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_wr(wr), .i_rd(rd), .i_addr(addr),
    .i_data_in(data_in), .o_data_out(s_dout), .o_out_valid(s_ov), .o_full(s_full),
    .o_empty(s_empty), .o_count(s_cnt), .o_err(s_err)
  );

  psum_spad_acc #(.DATA_W(DW), .DEPTH(DEPTH), .SATURATE(1'b0)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_wr(wr), .i_rd(rd), .i_addr(addr),
    .i_data_in(data_in), .o_data_out(w_dout), .o_out_valid(w_ov), .o_full(w_full),
    .o_empty(w_empty), .o_count(w_cnt), .o_err(w_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: memory image per instance plus FIFO bookkeeping.
  int m_mem_s [DEPTH];
  int m_mem_w [DEPTH];
  int m_head, m_tail, m_count;
  int m_dout_s, m_dout_w, m_ov, m_err;
  bit m_prev_acc;
  bit m_last_v;
  int m_last_a, m_last_os, m_last_ow;
  int pre [DEPTH];

  function automatic int clamp16(input int s);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  function automatic int wrap16(input int s);
    logic signed [15:0] t;
    t = 16'(s);
    return int'(t);
  endfunction

  function automatic logic [31:0] w16(input int v);
    return {16'h0, v[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    assert (act === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dout_s"}, 32'(s_dout), w16(m_dout_s));
    chk({tag, ".dout_w"}, 32'(w_dout), w16(m_dout_w));
    chk({tag, ".ov"}, 32'(s_ov), 32'(m_ov));
    chk({tag, ".ov_w"}, 32'(w_ov), 32'(m_ov));
    chk({tag, ".err"}, 32'(s_err), 32'(m_err));
    chk({tag, ".count"}, 32'(s_cnt), 32'(m_count));
    chk({tag, ".full"}, 32'(s_full), 32'(m_count == DEPTH));
    chk({tag, ".empty"}, 32'(s_empty), 32'(m_count == 0));
  endtask

  task automatic step(input string tag, input bit md, input bit w, input bit r,
                      input int a, input int d);
    bit pop_ok, push_ok;
    int os, ow;
    mode = md; wr = w; rd = r; addr = AW'(a); data_in = DW'(d);
    @(posedge clk);
    m_ov = 0; m_err = 0; m_last_v = 0;
    if (m_prev_acc && !md) begin
      m_head = 0; m_tail = 0; m_count = 0;
    end else if (!md) begin
      pop_ok  = r && (m_count > 0);
      push_ok = w && ((m_count < DEPTH) || pop_ok);
      if (pop_ok) begin
        m_dout_s = m_mem_s[m_head];
        m_dout_w = m_mem_w[m_head];
        m_ov     = 1;
        m_head   = (m_head + 1) % DEPTH;
        m_count--;
      end
      if (push_ok) begin
        m_mem_s[m_tail] = d;
        m_mem_w[m_tail] = d;
        m_tail = (m_tail + 1) % DEPTH;
        m_count++;
      end
      m_err = int'((w && !push_ok) || (r && !pop_ok));
    end else begin
      os = m_mem_s[a];
      ow = m_mem_w[a];
      if (r) begin
        m_dout_s = os; m_dout_w = ow; m_ov = 1;
      end
      if (w) begin
        m_mem_s[a] = clamp16(os + d);
        m_mem_w[a] = wrap16(ow + d);
        m_last_v = 1; m_last_a = a; m_last_os = os; m_last_ow = ow;
      end
    end
    m_prev_acc = md;
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag, input bit md, input bit w, input bit r);
    rst = 1'b1; mode = md; wr = w; rd = r;
    @(posedge clk);
    if (m_last_v) begin
      m_mem_s[m_last_a] = m_last_os;
      m_mem_w[m_last_a] = m_last_ow;
    end
    m_last_v = 0;
    m_head = 0; m_tail = 0; m_count = 0;
    m_dout_s = 0; m_dout_w = 0; m_ov = 0; m_err = 0;
    m_prev_acc = 0;
    #1;
    rst = 1'b0;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; data_in = '0;
    m_last_v = 0; m_prev_acc = 0;
    do_reset("reset0", 1'b0, 1'b0, 1'b0);
    do_reset("reset1", 1'b0, 1'b1, 1'b1);

    // Fill to full, overflow, drain in order.
    for (int i = 1; i <= DEPTH; i++) step("fill", 0, 1, 0, 0, i);
    step("overflow", 0, 1, 0, 0, 555);
    for (int i = 1; i <= DEPTH; i++) step("drain", 0, 0, 1, 0, 0);
    step("rd_empty", 0, 0, 1, 0, 0);
    step("rdwr_empty", 0, 1, 1, 0, 42);
    for (int i = 0; i < DEPTH - 1; i++) step("refill", 0, 1, 0, 0, 1000 + i);
    step("full_rdwr", 0, 1, 1, 0, 99);
    for (int i = 0; i < DEPTH; i++) step("drain2", 0, 0, 1, 0, 0);

    // Wrap pointers several times.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 20; i++) step("wrap_push", 0, 1, 0, 0, $urandom_range(0, 65535) - 32768);
      for (int i = 0; i < 20; i++) step("wrap_pop", 0, 0, 1, 0, 0);
    end

    // Random FIFO traffic.
    for (int i = 0; i < 200; i++)
      step("rnd_fifo", 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
           $urandom_range(0, 65535) - 32768);

    // Preload memory through a fresh FIFO pass (1->0 clears the pointers).
    step("to_acc", 1, 0, 0, 0, 0);
    step("to_fifo", 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) pre[i] = $urandom_range(0, 65535) - 32768;
    pre[5] = 0; pre[2] = 32760; pre[3] = -32768;
    for (int i = 0; i < DEPTH; i++) step("preload", 0, 1, 0, 0, pre[i]);
    step("enter_acc", 1, 0, 0, 0, 0);

    // Back-to-back hazard on one address.
    step("acc5a", 1, 1, 0, 5, 3);
    step("acc5b", 1, 1, 0, 5, 4);
    step("acc5c", 1, 1, 0, 5, -2);
    step("rd5", 1, 0, 1, 5, 0);

    // Saturation versus wrap at both ends of the range.
    step("acc2", 1, 1, 0, 2, 100);
    step("rd2", 1, 0, 1, 2, 0);
    step("acc3", 1, 1, 0, 3, -100);
    step("rd3", 1, 0, 1, 3, 0);

    // rd+wr same address returns the pre-accumulate value; then read it back.
    step("rdwr9", 1, 1, 1, 9, 1234);
    step("rd9", 1, 0, 1, 9, 0);

    // Random ACC traffic on a small address window to stress forwarding.
    for (int i = 0; i < 300; i++)
      step("rnd_acc", 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3), $urandom_range(0, 65535) - 32768);
    for (int i = 0; i < 4; i++) step("acc_dump", 1, 0, 1, i, 0);

    // Reset right after an accumulate drops the pending write.
    step("acc7", 1, 1, 0, 7, 50);
    do_reset("reset_mid", 1'b1, 1'b1, 1'b1);
    step("rd7", 1, 0, 1, 7, 0);

    // FIFO usable again after returning from ACC.
    step("back_fifo", 0, 0, 0, 0, 0);
    step("post_push", 0, 1, 0, 0, 77);
    step("post_pop", 0, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
